// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: drives the instruction SRAM address, captures the
// returned words into a small FIFO tagged with their PC, and hands them to decode
// with valid/ready. A branch redirect flushes queued and in-flight fetches.
module inst_prefetch_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fetch_en,
  output logic [ADDR_WIDTH-1:0]       addr_0,
  input  logic [DATA_WIDTH-1:0]       inst_in,
  input  logic                        redirect_valid,
  input  logic [ADDR_WIDTH-1:0]       redirect_pc,
  output logic                        ir_valid,
  input  logic                        ir_ready,
  output logic [DATA_WIDTH-1:0]       ir_out,
  output logic [ADDR_WIDTH-1:0]       ir_pc,
  output logic [$clog2(DEPTH):0]      q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  pending_q, pending_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

  logic                  push;
  logic                  pop;
  logic                  req;
  logic [CW:0]           inflight;

  assign addr_0   = fetch_pc_q;
  assign q_count  = count_q;
  assign ir_valid = (count_q != '0);
  assign ir_out   = data_q[rd_ptr_q];
  assign ir_pc    = pc_q[rd_ptr_q];

  // Handshake and credit decisions; a redirect suppresses push, pop and request,
  // and the credit counts the in-flight word so a capture never finds the queue full
  always_comb begin
    inflight = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    push     = pending_q && !redirect_valid;
    pop      = (count_q != '0) && ir_ready && !redirect_valid;
    req      = fetch_en && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  end

  // Next-state for fetch PC, in-flight tracking, pointers and occupancy
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (req) begin
        pending_d  = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= '0;
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage: captured word and its PC written at the tail on push;
  // cleared on reset so the head outputs read zero out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= inst_in;
      pc_q[wr_ptr_q]   <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: directed scenarios plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_inst_prefetch_queue;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic [AW-1:0] addr_0;
  logic [DW-1:0] inst_in;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic [DW-1:0] ir_out;
  logic [AW-1:0] ir_pc;
  logic [CW-1:0] q_count;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of PCs held, plus the fetch PC and the in-flight fetch
  logic [AW-1:0] mq [$];
  logic [AW-1:0] m_fpc;
  logic [AW-1:0] m_ppc;
  bit            m_pend;

  logic [AW-1:0] wrap_exp [4];

  inst_prefetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .addr_0(addr_0),
    .inst_in(inst_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_out(ir_out), .ir_pc(ir_pc),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: word at address i is A000+i, returned one edge after sampling
  always @(posedge clk) inst_in <= 16'hA000 + addr_0;

  task model_reset();
    mq.delete();
    m_fpc  = '0;
    m_ppc  = '0;
    m_pend = 0;
  endtask

  task model_edge();
    bit            req;
    bit            pend_now;
    logic [AW-1:0] ppc_now;
    if (redirect_valid) begin
      mq.delete();
      m_pend = 0;
      m_fpc  = redirect_pc;
    end else begin
      req      = fetch_en && ((mq.size() + int'(m_pend)) < DEPTH);
      pend_now = m_pend;
      ppc_now  = m_ppc;
      if (mq.size() != 0 && ir_ready) void'(mq.pop_front());
      if (pend_now) mq.push_back(ppc_now);
      if (req) begin
        m_pend = 1;
        m_ppc  = m_fpc;
        m_fpc  = m_fpc + 16'd1;
      end else begin
        m_pend = 0;
      end
    end
  endtask

  task tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task do_reset();
    reset          = 1'b1;
    fetch_en       = 1'b1;
    ir_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task test_reset();
    reset = 1'b1; fetch_en = 1'b1; ir_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    #1;
    checks++;
    if (ir_valid !== 1'b0 || q_count !== '0 || addr_0 !== '0 || ir_out !== '0 || ir_pc !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b cnt=%0d addr=%h out=%h pc=%h expected all zero",
               ir_valid, q_count, addr_0, ir_out, ir_pc);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task test_stream();
    do_reset();
    tick();
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_first_edge: got valid=%b expected 0", ir_valid);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== AW'(k) || ir_out !== DW'(16'hA000 + k)) begin
        errors++;
        $display("[TB] FAIL stream_word%0d: got valid=%b pc=%h out=%h expected 1 %h %h",
                 k, ir_valid, ir_pc, ir_out, AW'(k), DW'(16'hA000 + k));
      end
      tick();
    end
  endtask

  task test_backpressure();
    int got;
    do_reset();
    ir_ready = 1'b0;
    repeat (10) tick();
    checks++;
    if (q_count !== CW'(4) || addr_0 !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL backpressure_full: got cnt=%0d addr=%h expected 4 0004", q_count, addr_0);
    end
    ir_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (ir_valid) begin
        checks++;
        if (ir_pc !== AW'(got) || ir_out !== DW'(16'hA000 + got)) begin
          errors++;
          $display("[TB] FAIL backpressure_order: got pc=%h out=%h expected %h %h",
                   ir_pc, ir_out, AW'(got), DW'(16'hA000 + got));
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("[TB] FAIL backpressure_count: got %0d delivered expected 8", got);
    end
  endtask

  task test_redirect();
    do_reset();
    ir_ready = 1'b0;
    repeat (4) tick();
    checks++;
    if (q_count !== CW'(3)) begin
      errors++;
      $display("[TB] FAIL redirect_setup: got cnt=%0d expected 3", q_count);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (q_count !== '0 || ir_valid !== 1'b0 || addr_0 !== 16'h0040) begin
      errors++;
      $display("[TB] FAIL redirect_flush: got cnt=%0d valid=%b addr=%h expected 0 0 0040",
               q_count, ir_valid, addr_0);
    end
    ir_ready = 1'b1;
    tick();
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_gap: got valid=%b expected 0", ir_valid);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 16'h0040 || ir_out !== 16'hA040) begin
      errors++;
      $display("[TB] FAIL redirect_target: got valid=%b pc=%h out=%h expected 1 0040 A040",
               ir_valid, ir_pc, ir_out);
    end
  endtask

  task test_wrap();
    int got;
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
    ir_ready       = 1'b1;
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      if (ir_valid) begin
        checks++;
        if (ir_pc !== wrap_exp[got] || ir_out !== DW'(16'hA000 + wrap_exp[got])) begin
          errors++;
          $display("[TB] FAIL wrap_pc%0d: got pc=%h out=%h expected %h %h",
                   got, ir_pc, ir_out, wrap_exp[got], DW'(16'hA000 + wrap_exp[got]));
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("[TB] FAIL wrap_count: got %0d delivered expected 4", got);
    end
  endtask

  task test_reset_mid();
    do_reset();
    ir_ready = 1'b0;
    repeat (4) tick();
    checks++;
    if (q_count !== CW'(3)) begin
      errors++;
      $display("[TB] FAIL midreset_setup: got cnt=%0d expected 3", q_count);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ir_valid !== 1'b0 || q_count !== '0 || addr_0 !== '0 || ir_out !== '0 || ir_pc !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got valid=%b cnt=%0d addr=%h out=%h pc=%h expected all zero",
               ir_valid, q_count, addr_0, ir_out, ir_pc);
    end
    @(negedge clk);
    reset    = 1'b0;
    ir_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 16'h0000 || ir_out !== 16'hA000) begin
      errors++;
      $display("[TB] FAIL midreset_restart: got valid=%b pc=%h out=%h expected 1 0000 A000",
               ir_valid, ir_pc, ir_out);
    end
  endtask

  task test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      fetch_en       = ~fetch_en;
      ir_ready       = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = AW'($urandom);
      checks++;
      if (q_count !== CW'(mq.size()) || q_count > CW'(DEPTH)) begin
        errors++;
        $display("[TB] FAIL random_count c%0d: got %0d expected %0d", cyc, q_count, mq.size());
      end
      checks++;
      if (addr_0 !== m_fpc) begin
        errors++;
        $display("[TB] FAIL random_addr c%0d: got %h expected %h", cyc, addr_0, m_fpc);
      end
      checks++;
      if (ir_valid !== (mq.size() != 0)) begin
        errors++;
        $display("[TB] FAIL random_valid c%0d: got %b expected %b", cyc, ir_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        checks++;
        if (ir_pc !== mq[0] || ir_out !== DW'(16'hA000 + mq[0])) begin
          errors++;
          $display("[TB] FAIL random_head c%0d: got pc=%h out=%h expected %h %h",
                   cyc, ir_pc, ir_out, mq[0], DW'(16'hA000 + mq[0]));
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
